// File: rtl/cv_copy_coord_if.sv
// Bus between the copy sequencer and the copy coordinate generator.
// master: sequencer side (drives start/params/step codes, reads flags/addresses).
// slave : coordinate generator side.
interface cv_copy_coord_if;
  logic        i_start;
  logic [9:0]  i_srcX;
  logic [8:0]  i_srcY;
  logic [9:0]  i_dstX;
  logic [8:0]  i_dstY;
  logic [9:0]  i_width;
  logic [8:0]  i_height;
  logic [2:0]  i_nextX;
  logic [2:0]  i_nextY;
  logic        i_exitSig;
  logic        o_active;
  logic        o_isWidthNot1;
  logic        o_xb_0;
  logic        o_wb_0;
  logic        o_currPairIsLineLast;
  logic        o_nextPairIsLineLast;
  logic        o_endVertical;
  logic [17:0] o_srcAddr;
  logic [17:0] o_dstAddr;
  logic [15:0] o_dbgSteps;

  modport master (
    output i_start, i_srcX, i_srcY, i_dstX, i_dstY, i_width, i_height,
           i_nextX, i_nextY, i_exitSig,
    input  o_active, o_isWidthNot1, o_xb_0, o_wb_0, o_currPairIsLineLast,
           o_nextPairIsLineLast, o_endVertical, o_srcAddr, o_dstAddr, o_dbgSteps
  );

  modport slave (
    input  i_start, i_srcX, i_srcY, i_dstX, i_dstY, i_width, i_height,
           i_nextX, i_nextY, i_exitSig,
    output o_active, o_isWidthNot1, o_xb_0, o_wb_0, o_currPairIsLineLast,
           o_nextPairIsLineLast, o_endVertical, o_srcAddr, o_dstAddr, o_dbgSteps
  );
endinterface

// File: rtl/cv_copy_coord.sv
// VRAM rectangle copy coordinate generator. Tracks the current 32-bit pair
// (two halfwords) and line of a copy, produces wrapped source/destination
// word addresses and line-end flags for the copy sequencer.
// Optional step counter: define CV_COPY_COORD_DBG_EN to build o_dbgSteps.
module cv_copy_coord (
  input  logic             clk,
  input  logic             nRst,
  cv_copy_coord_if.slave   bus
);

  // Step codes from the sequencer
  localparam logic [2:0] X_NEXT  = 3'd1;
  localparam logic [2:0] Y_NEXT  = 3'd4;
  localparam logic [2:0] XY_BACK = 3'd6;

  logic        active_q,   active_d;
  logic [9:0]  src_x_q,    src_x_d;
  logic [8:0]  src_y_q,    src_y_d;
  logic [8:0]  dst_xp_q,   dst_xp_d;   // dstX in pair units; bit 0 is irrelevant
  logic [8:0]  dst_y_q,    dst_y_d;
  logic [10:0] w_q,        w_d;        // width in halfwords, 1..1024
  logic [9:0]  h_q,        h_d;        // height in lines, 1..512
  logic [10:0] np_q,       np_d;       // pairs touched per line, 1..513
  logic [9:0]  pair_q,     pair_d;
  logic [8:0]  line_q,     line_d;

  logic [10:0] w_new;
  logic [9:0]  h_new;
  logic [10:0] sx_ext;
  logic [10:0] end_x;
  logic [10:0] np_new;
  logic        pair_last;
  logic        line_last;

  // Decode new-copy parameters; NP spans from the pair holding the first
  // pixel to the pair holding the last one.
  always_comb begin
    w_new  = (bus.i_width  == 10'd0) ? 11'd1024 : {1'b0, bus.i_width};
    h_new  = (bus.i_height == 9'd0)  ? 10'd512  : {1'b0, bus.i_height};
    sx_ext = {1'b0, bus.i_srcX};
    end_x  = sx_ext + w_new - 11'd1;
    np_new = (end_x >> 1) - (sx_ext >> 1) + 11'd1;
  end

  assign pair_last = ({1'b0, pair_q} == (np_q - 11'd1));
  assign line_last = ({1'b0, line_q} == (h_q - 10'd1));

  // Next-state: start (re)loads, exit stops, otherwise step codes move counters
  always_comb begin
    active_d = active_q;
    src_x_d  = src_x_q;
    src_y_d  = src_y_q;
    dst_xp_d = dst_xp_q;
    dst_y_d  = dst_y_q;
    w_d      = w_q;
    h_d      = h_q;
    np_d     = np_q;
    pair_d   = pair_q;
    line_d   = line_q;
    if (bus.i_start) begin
      active_d = 1'b1;
      src_x_d  = bus.i_srcX;
      src_y_d  = bus.i_srcY;
      dst_xp_d = bus.i_dstX[9:1];
      dst_y_d  = bus.i_dstY;
      w_d      = w_new;
      h_d      = h_new;
      np_d     = np_new;
      pair_d   = '0;
      line_d   = '0;
    end else if (active_q) begin
      if (bus.i_exitSig) begin
        active_d = 1'b0;
      end else begin
        // Stepping past the last pair/line wraps rather than overrunning
        if (bus.i_nextX == X_NEXT)       pair_d = pair_last ? 10'd0 : pair_q + 10'd1;
        else if (bus.i_nextX == XY_BACK) pair_d = '0;
        if (bus.i_nextY == Y_NEXT)       line_d = line_last ? 9'd0 : line_q + 9'd1;
        else if (bus.i_nextY == XY_BACK) line_d = '0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      active_q <= 1'b0;
      src_x_q  <= '0;
      src_y_q  <= '0;
      dst_xp_q <= '0;
      dst_y_q  <= '0;
      w_q      <= '0;
      h_q      <= 10'd1;
      np_q     <= 11'd1;
      pair_q   <= '0;
      line_q   <= '0;
    end else begin
      active_q <= active_d;
      src_x_q  <= src_x_d;
      src_y_q  <= src_y_d;
      dst_xp_q <= dst_xp_d;
      dst_y_q  <= dst_y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      np_q     <= np_d;
      pair_q   <= pair_d;
      line_q   <= line_d;
    end
  end

  assign bus.o_active             = active_q;
  assign bus.o_xb_0               = src_x_q[0];
  assign bus.o_wb_0               = w_q[0];
  assign bus.o_isWidthNot1        = (w_q != 11'd1);
  assign bus.o_currPairIsLineLast = active_q & pair_last;
  assign bus.o_nextPairIsLineLast = active_q & (({1'b0, pair_q} + 11'd1) == (np_q - 11'd1));
  assign bus.o_endVertical        = active_q & line_last;

  // 9-bit sums give the VRAM wrap on both axes
  assign bus.o_srcAddr = {src_y_q + line_q, src_x_q[9:1] + pair_q[8:0]};
  assign bus.o_dstAddr = {dst_y_q + line_q, dst_xp_q     + pair_q[8:0]};

`ifdef CV_COPY_COORD_DBG_EN
  logic [15:0] dbg_q, dbg_d;

  // Count active cycles carrying any non-as-is step code
  always_comb begin
    dbg_d = dbg_q;
    if (bus.i_start) dbg_d = '0;
    else if (active_q && (bus.i_nextX == X_NEXT || bus.i_nextX == XY_BACK ||
                          bus.i_nextY == Y_NEXT || bus.i_nextY == XY_BACK))
      dbg_d = dbg_q + 16'd1;
  end

  // Step counter register
  always_ff @(posedge clk) begin
    if (!nRst) dbg_q <= '0;
    else       dbg_q <= dbg_d;
  end

  assign bus.o_dbgSteps = dbg_q;
`else
  assign bus.o_dbgSteps = '0;
`endif

endmodule

// File: tb/tb_cv_copy_coord.sv
// Bench for cv_copy_coord: directed copies, an abstract model of the
// counters checked every cycle, and literal expectations for key points.
module tb_cv_copy_coord;
  logic clk = 1'b0;
  logic nRst;
  cv_copy_coord_if bus();

  cv_copy_coord dut (.clk(clk), .nRst(nRst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state, plain integers
  int m_active, m_sx, m_sy, m_dx, m_dy, m_w, m_h, m_np, m_pair, m_line, m_dbg;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int addr(input int y, input int x, input int line, input int pair);
    return (((y + line) % 512) * 512) + (((x / 2) + pair) % 512);
  endfunction

  // Model update at each rising edge from the inputs held across it
  always @(posedge clk) begin
    chk_en = 1'b1;
    if (!nRst) begin
      m_active = 0; m_sx = 0; m_sy = 0; m_dx = 0; m_dy = 0;
      m_w = 0; m_h = 1; m_np = 1; m_pair = 0; m_line = 0; m_dbg = 0;
    end else if (bus.i_start) begin
      m_active = 1;
      m_sx = bus.i_srcX; m_sy = bus.i_srcY; m_dx = bus.i_dstX; m_dy = bus.i_dstY;
      m_w = (bus.i_width == 0) ? 1024 : int'(bus.i_width);
      m_h = (bus.i_height == 0) ? 512 : int'(bus.i_height);
      m_np = ((m_sx + m_w - 1) / 2) - (m_sx / 2) + 1;
      m_pair = 0; m_line = 0; m_dbg = 0;
    end else if (m_active == 1) begin
      if (bus.i_nextX inside {3'd1, 3'd6} || bus.i_nextY inside {3'd4, 3'd6})
        m_dbg = (m_dbg + 1) % 65536;
      if (bus.i_exitSig) m_active = 0;
      else begin
        if (bus.i_nextX == 3'd1) m_pair = (m_pair == m_np - 1) ? 0 : m_pair + 1;
        else if (bus.i_nextX == 3'd6) m_pair = 0;
        if (bus.i_nextY == 3'd4) m_line = (m_line == m_h - 1) ? 0 : m_line + 1;
        else if (bus.i_nextY == 3'd6) m_line = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("active", int'(bus.o_active), m_active);
      chk("srcAddr", int'(bus.o_srcAddr), addr(m_sy, m_sx, m_line, m_pair));
      chk("dstAddr", int'(bus.o_dstAddr), addr(m_dy, m_dx, m_line, m_pair));
      chk("currLast", int'(bus.o_currPairIsLineLast), (m_active == 1 && m_pair == m_np - 1) ? 1 : 0);
      chk("nextLast", int'(bus.o_nextPairIsLineLast), (m_active == 1 && m_pair + 1 == m_np - 1) ? 1 : 0);
      chk("endVert", int'(bus.o_endVertical), (m_active == 1 && m_line == m_h - 1) ? 1 : 0);
`ifdef CV_COPY_COORD_DBG_EN
      chk("dbgSteps", int'(bus.o_dbgSteps), m_dbg);
`else
      chk("dbgSteps", int'(bus.o_dbgSteps), 0);
`endif
      if (m_active == 1) begin
        chk("xb_0", int'(bus.o_xb_0), m_sx % 2);
        chk("wb_0", int'(bus.o_wb_0), m_w % 2);
        chk("wNot1", int'(bus.o_isWidthNot1), (m_w != 1) ? 1 : 0);
      end
    end
  end

  task automatic start(input int sx, input int sy, input int dx, input int dy,
                       input int w, input int h, input bit ex = 1'b0);
    bus.i_srcX = 10'(sx); bus.i_srcY = 9'(sy);
    bus.i_dstX = 10'(dx); bus.i_dstY = 9'(dy);
    bus.i_width = 10'(w); bus.i_height = 9'(h);
    bus.i_start = 1'b1; bus.i_exitSig = ex;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_exitSig = 1'b0;
  endtask

  task automatic step(input int x, input int y);
    bus.i_nextX = 3'(x); bus.i_nextY = 3'(y);
    @(posedge clk); #1;
    bus.i_nextX = 3'd0; bus.i_nextY = 3'd0;
  endtask

  initial begin
    nRst = 1'b0;
    bus.i_start = 0; bus.i_srcX = 0; bus.i_srcY = 0; bus.i_dstX = 0; bus.i_dstY = 0;
    bus.i_width = 0; bus.i_height = 0; bus.i_nextX = 0; bus.i_nextY = 0; bus.i_exitSig = 0;
    // Reset must win over start and codes
    bus.i_start = 1'b1; bus.i_nextX = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_start = 1'b0; bus.i_nextX = 3'd0;
    chk("rst active", int'(bus.o_active), 0);
    chk("rst srcAddr", int'(bus.o_srcAddr), 0);
    chk("rst dbg", int'(bus.o_dbgSteps), 0);
    nRst = 1'b1;
    @(posedge clk); #1;

    // Basic: srcX=0 W=4 H=2 -> NP=2
    start(0, 0, 4, 3, 4, 2);
    chk("b nextLast", int'(bus.o_nextPairIsLineLast), 1);
    step(1, 0);
    chk("b currLast", int'(bus.o_currPairIsLineLast), 1);
    step(6, 4);
    chk("b endVert", int'(bus.o_endVertical), 1);
    chk("b srcAddr", int'(bus.o_srcAddr), 512);
    chk("b dstAddr", int'(bus.o_dstAddr), 4 * 512 + 2);

    // Odd start: srcX=1 W=4 -> NP=3
    start(1, 10, 0, 0, 4, 3);
    chk("o xb_0", int'(bus.o_xb_0), 1);
    chk("o wb_0", int'(bus.o_wb_0), 0);
    step(1, 0);
    chk("o nextLast", int'(bus.o_nextPairIsLineLast), 1);
    chk("o currLast0", int'(bus.o_currPairIsLineLast), 0);
    step(1, 0);
    chk("o currLast", int'(bus.o_currPairIsLineLast), 1);
    step(1, 0);  // overrun wraps to pair 0
    chk("o wrap", int'(bus.o_srcAddr), 10 * 512);

    // VRAM wrap: srcX=1022 srcY=511
    start(1022, 511, 1020, 0, 4, 2);
    chk("w srcAddr0", int'(bus.o_srcAddr), 511 * 512 + 511);
    step(1, 0);
    chk("w pairWrap", int'(bus.o_srcAddr), 511 * 512);
    step(0, 4);
    chk("w lineWrap", int'(bus.o_srcAddr), 0);
    step(3, 5);  // as-is codes
    chk("w asis", int'(bus.o_srcAddr), 0);

    // Full-size copy: W=0,H=0 -> NP=512, H=512
    start(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 511; i++) begin
      if (i == 510) chk("f endVert510", int'(bus.o_endVertical), 0);
      step(1, 4);
    end
    chk("f endVert511", int'(bus.o_endVertical), 1);
    chk("f currLast", int'(bus.o_currPairIsLineLast), 1);
    step(1, 4);
    chk("f wrap", int'(bus.o_srcAddr), 0);

    // Single-pixel width
    start(5, 0, 0, 0, 1, 1);
    chk("s wNot1", int'(bus.o_isWidthNot1), 0);
    chk("s currLast", int'(bus.o_currPairIsLineLast), 1);
    chk("s nextLast", int'(bus.o_nextPairIsLineLast), 0);

    // Exit then ignored codes; dbg step count
    start(100, 50, 200, 60, 16, 8);
    step(1, 0); step(0, 4); step(1, 4); step(6, 0); step(1, 6);
`ifdef CV_COPY_COORD_DBG_EN
    chk("d dbg5", int'(bus.o_dbgSteps), 5);
`else
    chk("d dbg0", int'(bus.o_dbgSteps), 0);
`endif
    chk("e preAddr", int'(bus.o_srcAddr), 50 * 512 + 51);
    bus.i_exitSig = 1'b1;
    @(posedge clk); #1;
    bus.i_exitSig = 1'b0;
    chk("e active", int'(bus.o_active), 0);
    step(1, 4);
    chk("e hold", int'(bus.o_srcAddr), 50 * 512 + 51);
    chk("e flags", int'(bus.o_currPairIsLineLast), 0);

    // Mid-copy reset
    start(100, 50, 200, 60, 16, 8);
    step(1, 4);
    nRst = 1'b0;
    @(posedge clk); #1;
    nRst = 1'b1;
    chk("r active", int'(bus.o_active), 0);
    chk("r srcAddr", int'(bus.o_srcAddr), 0);
    chk("r dstAddr", int'(bus.o_dstAddr), 0);

    // Start and exit together, start also overriding codes
    start(8, 2, 0, 0, 8, 4);
    step(1, 4);
    bus.i_nextX = 3'd1; bus.i_nextY = 3'd4;
    start(40, 7, 0, 0, 8, 4, 1'b1);
    bus.i_nextX = 3'd0; bus.i_nextY = 3'd0;
    chk("x active", int'(bus.o_active), 1);
    chk("x srcAddr", int'(bus.o_srcAddr), 7 * 512 + 20);
    chk("x dbg", int'(bus.o_dbgSteps), 0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
